// File: rtl/sal_ref_ctrl_pkg.sv
// Shared DDR refresh parameters and helpers for the refresh manager slice.
package sal_ref_ctrl_pkg;

    localparam int unsigned T_REFI_WIDTH = 16;
    localparam int unsigned T_RFC_WIDTH  = 10;
    localparam int unsigned REF_PEND_MAX = 8;
    localparam int unsigned PEND_WIDTH   = 4;

    // Legal credit limits are 1..15; out-of-range values are pinned to the nearest bound.
    function automatic logic [PEND_WIDTH-1:0] clamp_pend_max(input int unsigned m);
        logic [PEND_WIDTH-1:0] r;
        if (m < 1) begin
            r = 4'd1;
        end else if (m > 15) begin
            r = 4'd15;
        end else begin
            r = m[PEND_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sal_ref_ctrl_timing_cntr.sv
// Reloadable down-counter: loads reset_value_i on reset_cmd_i, then counts to zero and holds.
module sal_timing_cntr #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reset_cmd_i,
    input  logic [WIDTH-1:0] reset_value_i,
    output logic             is_zero_o
);

    logic [WIDTH-1:0] cnt;

    // Load on command, otherwise decrement until zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reset_cmd_i) begin
            cnt <= reset_value_i;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_zero_o = (cnt == '0);

endmodule

// File: rtl/sal_ref_ctrl.sv
// All-bank refresh manager: tREFI credit accounting, bank drain, REF request and tRFC hold-off.
module sal_ref_ctrl
    import sal_ref_ctrl_pkg::*;
#(
    parameter int unsigned BK_CNT     = 4,
    parameter int unsigned REFI_WIDTH = T_REFI_WIDTH,
    parameter int unsigned RFC_WIDTH  = T_RFC_WIDTH,
    parameter int unsigned PEND_MAX   = REF_PEND_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ref_en_i,
    input  logic [REFI_WIDTH-1:0] t_refi_m1_i,
    input  logic [RFC_WIDTH-1:0]  t_rfc_m1_i,
    input  logic [BK_CNT-1:0]     bk_idle_i,
    input  logic                  ref_gnt_i,
    output logic                  block_act_o,
    output logic                  ref_req_o,
    output logic [3:0]            pend_cnt_o,
    output logic                  ovf_o
);

    typedef enum logic [1:0] {IDLE, DRAIN, REQ, RFC} ref_state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_LIM = clamp_pend_max(PEND_MAX);

    ref_state_t              state;
    ref_state_t              state_next;
    logic [REFI_WIDTH-1:0]   refi_cnt;
    logic                    armed;
    logic                    tick;
    logic                    gnt_acc;
    logic [PEND_WIDTH-1:0]   pend;
    logic [PEND_WIDTH-1:0]   pend_next;
    logic                    ovf_set;
    logic                    ovf;
    logic                    rfc_zero;
    logic                    all_idle;

    assign all_idle = &bk_idle_i;
    assign gnt_acc  = ref_req_o & ref_gnt_i;

    // The counter leaves reset at 0; 'armed' keeps that first reload from counting as a tick,
    // so the first obligation arrives a full tREFI after reset release.
    assign tick = ref_en_i & armed & (refi_cnt == '0);

    // tREFI auto-reload down-counter, parked at the reload value while refresh is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refi_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (!ref_en_i || refi_cnt == '0) begin
                refi_cnt <= t_refi_m1_i;
            end else begin
                refi_cnt <= refi_cnt - 1'b1;
            end
        end
    end

    // Credit update: +tick, -grant, saturating at the limit with overflow flagged.
    always_comb begin
        pend_next = pend;
        ovf_set   = 1'b0;
        case ({tick, gnt_acc})
            2'b10: begin
                if (pend == PEND_LIM) begin
                    ovf_set = 1'b1;
                end else begin
                    pend_next = pend + 4'd1;
                end
            end
            2'b01: begin
                if (pend != '0) begin
                    pend_next = pend - 4'd1;
                end
            end
            default: pend_next = pend;
        endcase
    end

    // Credit register and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else begin
            pend <= pend_next;
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

    // tRFC window starts on the grant cycle.
    sal_timing_cntr #(
        .WIDTH (RFC_WIDTH)
    ) u_rfc_cntr (
        .clk           (clk),
        .rst_n         (rst_n),
        .reset_cmd_i   (gnt_acc),
        .reset_value_i (t_rfc_m1_i),
        .is_zero_o     (rfc_zero)
    );

    // Refresh sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_next  = state;
        block_act_o = 1'b0;
        ref_req_o   = 1'b0;
        case (state)
            IDLE: begin
                if (ref_en_i && pend != '0 && (pend == PEND_LIM || all_idle)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                block_act_o = 1'b1;
                if (all_idle) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                block_act_o = 1'b1;
                ref_req_o   = 1'b1;
                if (ref_gnt_i) begin
                    state_next = RFC;
                end
            end
            RFC: begin
                block_act_o = 1'b1;
                if (rfc_zero) begin
                    state_next = (pend != '0 && ref_en_i) ? DRAIN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pend_cnt_o = pend;
    assign ovf_o      = ovf;

    a_banks_idle_in_req: assert property (
        @(posedge clk) disable iff (!rst_n) (state == REQ) |-> all_idle
    );

endmodule
